sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of requesters (2..8).
REQ-002 Parameter DATA_W, default 16, data width (8/16/32); BE_W = DATA_W/8.
REQ-003 Parameter ADDR_W, default 24, byte address width.
REQ-004 clk  in  1  clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 p_rd  in  NUM_PORTS  per-port read request, held until p_gnt.
REQ-007 p_wr  in  NUM_PORTS*BE_W  per-port write byte enables; nonzero = write request.
REQ-008 p_addr  in  NUM_PORTS*ADDR_W  per-port address.
REQ-009 p_wdata  in  NUM_PORTS*DATA_W  per-port write data.
REQ-010 p_gnt  out  NUM_PORTS  one-cycle pulse: request captured.
REQ-011 p_rvalid  out  NUM_PORTS  one-cycle read-complete pulse to owner.
REQ-012 p_wvalid  out  NUM_PORTS  one-cycle write-complete pulse to owner.
REQ-013 p_rdata  out  DATA_W  shared read data, valid with any p_rvalid bit, else 0.
REQ-014 m_rdy  in  1  controller ready; request accepted when m_rdy & (m_rd | m_wr!=0).
REQ-015 m_rd, m_wr[BE_W], m_addr[ADDR_W], m_wdata[DATA_W]  out  registered request to controller.
REQ-016 m_rvalid, m_wvalid  in  1  controller completion pulses; m_rdata  in  DATA_W.

Function
REQ-017 Port k requesting = p_rd[k] | (p_wr slice k != 0); if both, read wins and write enables are forwarded as 0.
REQ-018 States: IDLE, ISSUE, WAIT; one transaction outstanding at a time.
REQ-019 IDLE: if any port requesting, select winner, register its rd/wr/addr/wdata into m_*, record owner, pulse p_gnt[owner] next cycle, go ISSUE.
REQ-020 Latency: request present in cycle N -> p_gnt and m_* valid in cycle N+1.
REQ-021 ISSUE: hold m_* stable; on cycle with m_rdy=1 clear m_rd/m_wr at next edge, go WAIT.
REQ-022 WAIT: on m_rvalid pulse p_rvalid[owner] same cycle with p_rdata=m_rdata; on m_wvalid pulse p_wvalid[owner]; go IDLE next cycle.
REQ-023 Back-to-back: completion in cycle M -> next grant no earlier than M+2.
REQ-024 Round-robin: pointer starts at 0; search order ptr, ptr+1, ..., wrapping mod NUM_PORTS; after grant to k, ptr = (k+1) mod NUM_PORTS.
REQ-025 Port k with NUM_PORTS-1 wraps to ptr 0.
REQ-026 Requests in ISSUE/WAIT are not sampled; requester still holding request during p_gnt cycle is not re-granted for that same request (requester drops it after p_gnt).
REQ-027 m_rvalid/m_wvalid while in IDLE or ISSUE ignored; no p_*valid pulse.
REQ-028 m_rvalid and m_wvalid both high in WAIT: forward only the one matching the recorded direction.
REQ-029 No request in IDLE: m_* stay 0, pointer unchanged.

Reset
REQ-030 On rst: state IDLE, ptr 0, owner 0, p_gnt/p_rvalid/p_wvalid 0, p_rdata 0, m_rd/m_wr/m_addr/m_wdata 0.
REQ-031 rst mid-ISSUE/WAIT abandons transaction; completion arriving after reset is ignored.

Configuration
REQ-032 Macro SDRAM_ARB_PRIORITY_EN: defined -> port 0 wins whenever requesting in IDLE, ports 1..NUM_PORTS-1 round-robin among themselves, ptr unchanged by port-0 grants; undefined -> pure round-robin over all ports per REQ-024.

Verification
REQ-033 Single port 2 read addr 0x000100, controller returns 0xBEEF -> p_gnt[2] one cycle after request, m_rd=1 m_addr=0x000100, p_rvalid[2] with p_rdata=0xBEEF, no other port pulses.
REQ-034 All 4 ports request writes continuously from reset -> grant order 0,1,2,3,0, each p_wvalid to correct port, m_wr equals port's enables.
REQ-035 m_rdy held 0 for 10 cycles in ISSUE -> m_* stable all 10 cycles, accepted on first m_rdy=1 cycle.
REQ-036 Port 1 p_rd=1 and p_wr=2'b11 simultaneously -> m_rd=1, m_wr=0.
REQ-037 rst asserted in WAIT, then stray m_rvalid -> no p_rvalid, all outputs 0, next request from port 3 granted with ptr=0 order.
REQ-038 SDRAM_ARB_PRIORITY_EN defined, ports 0 and 2 requesting continuously -> port 0 granted every transaction; undefined -> alternates 0,2,0,2.

Source files
------------

// File: rtl/sdram_arbiter.sv
// ----------------------------------------------------------------------------
// sdram_arbiter
//   Multi-port front end for a single-outstanding SDRAM controller. Each port
//   raises a read (p_rd) or a write (nonzero byte enables on p_wr). One winner
//   is chosen in IDLE and its request is registered onto m_*. The request is
//   held until the controller takes it (m_rdy). The completion pulse is then
//   routed back to the owning port.
//
//   Arbitration is round-robin. The search starts at ptr, and after a grant
//   to port k the pointer moves to k+1.
//
//   Optional feature macro: SDRAM_ARB_PRIORITY_EN
//     defined   -> port 0 wins whenever it requests in IDLE and does not move
//                  the pointer. Ports 1..NUM_PORTS-1 round-robin among
//                  themselves.
//     undefined -> pure round-robin over all ports.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   p_rd[NUM_PORTS]          per-port read request (held until p_gnt)
//   p_wr[NUM_PORTS*BE_W]     per-port write byte enables (nonzero = write)
//   p_addr, p_wdata          per-port address / write data (flattened)
//   p_gnt                    one-cycle pulse: request captured
//   p_rvalid, p_wvalid       one-cycle completion pulses to the owner
//   p_rdata                  read data, valid with p_rvalid, else 0
//   m_rdy                    controller accepts m_* when high
//   m_rd, m_wr, m_addr, m_wdata  registered request to the controller
//   m_rvalid, m_wvalid, m_rdata  controller completion
// ----------------------------------------------------------------------------
module sdram_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 24
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            p_rd,
    input  logic [NUM_PORTS*(DATA_W/8)-1:0] p_wr,
    input  logic [NUM_PORTS*ADDR_W-1:0]     p_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]     p_wdata,
    output logic [NUM_PORTS-1:0]            p_gnt,
    output logic [NUM_PORTS-1:0]            p_rvalid,
    output logic [NUM_PORTS-1:0]            p_wvalid,
    output logic [DATA_W-1:0]               p_rdata,
    input  logic                            m_rdy,
    output logic                            m_rd,
    output logic [(DATA_W/8)-1:0]           m_wr,
    output logic [ADDR_W-1:0]               m_addr,
    output logic [DATA_W-1:0]               m_wdata,
    input  logic                            m_rvalid,
    input  logic                            m_wvalid,
    input  logic [DATA_W-1:0]               m_rdata
);

    localparam int BE_W = DATA_W / 8;
    localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic          own_rd;     // direction of the outstanding transaction

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] cand;     // ports taking part in round-robin
    logic                 pri0;     // port 0 overrides round-robin

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_req
        assign req[k] = p_rd[k] | (|p_wr[k*BE_W +: BE_W]);
    end

`ifdef SDRAM_ARB_PRIORITY_EN
    assign pri0 = req[0];
    assign cand = {req[NUM_PORTS-1:1], 1'b0};
`else
    assign pri0 = 1'b0;
    assign cand = req;
`endif

    // ------------------------------------------------------------------
    // Round-robin search
    //   The lowest requesting index at or above ptr wins. If there is
    //   none, the lowest requesting index below ptr wins (the wrap).
    //   Scanning downward lets the last hit be the lowest index.
    // ------------------------------------------------------------------
    logic          hi_found, lo_found;
    logic [PW-1:0] hi_idx, lo_idx;
    logic          any;
    logic [PW-1:0] win;
    logic [PW-1:0] ptr_nxt;

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (cand[k]) begin
                if (PW'(k) >= ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = PW'(k);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = PW'(k);
                end
            end
        end
    end

    always_comb begin
        any = pri0 | hi_found | lo_found;
        win = '0;
        if (pri0)
            win = '0;
        else if (hi_found)
            win = hi_idx;
        else if (lo_found)
            win = lo_idx;
        ptr_nxt = (win == PW'(NUM_PORTS - 1)) ? '0 : win + 1'b1;
    end

    // Winner's request fields
    logic                 sel_rd;
    logic [BE_W-1:0]      sel_wr;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic [NUM_PORTS-1:0] win_vec;

    always_comb begin
        sel_rd    = 1'b0;
        sel_wr    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        win_vec   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (win == PW'(k)) begin
                sel_rd     = p_rd[k];
                sel_wr     = p_wr[k*BE_W +: BE_W];
                sel_addr   = p_addr[k*ADDR_W +: ADDR_W];
                sel_wdata  = p_wdata[k*DATA_W +: DATA_W];
                win_vec[k] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Completion matching. Only the pulse that agrees with the recorded
    // direction finishes the transaction. Pulses seen outside WAIT are
    // dropped.
    // ------------------------------------------------------------------
    logic done_rd, done_wr;

    assign done_rd = (state == WAIT) &&  own_rd && m_rvalid && !rst;
    assign done_wr = (state == WAIT) && !own_rd && m_wvalid && !rst;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any)               state_nxt = ISSUE;
            ISSUE:   if (m_rdy)             state_nxt = WAIT;
            WAIT:    if (done_rd | done_wr) state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request register, owner tracking, grant pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            owner   <= '0;
            own_rd  <= 1'b0;
            p_gnt   <= '0;
            m_rd    <= 1'b0;
            m_wr    <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else begin
            p_gnt <= '0;
            case (state)
                IDLE: begin
                    if (any) begin
                        owner   <= win;
                        own_rd  <= sel_rd;
                        p_gnt   <= win_vec;
                        m_rd    <= sel_rd;
                        // A read takes precedence, so its write enables are
                        // not forwarded.
                        m_wr    <= sel_rd ? '0 : sel_wr;
                        m_addr  <= sel_addr;
                        m_wdata <= sel_wdata;
                        if (!pri0)
                            ptr <= ptr_nxt;
                    end
                end
                ISSUE: begin
                    // Clear the whole request once it is taken, so m_* reads
                    // as 0 whenever nothing is pending.
                    if (m_rdy) begin
                        m_rd    <= 1'b0;
                        m_wr    <= '0;
                        m_addr  <= '0;
                        m_wdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Completion routing
    // ------------------------------------------------------------------
    logic [NUM_PORTS-1:0] own_vec;

    always_comb begin
        own_vec = '0;
        for (int k = 0; k < NUM_PORTS; k++)
            own_vec[k] = (owner == PW'(k));
    end

    assign p_rvalid = done_rd ? own_vec : '0;
    assign p_wvalid = done_wr ? own_vec : '0;
    assign p_rdata  = done_rd ? m_rdata : '0;

endmodule

// File: tb/tb_sdram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sdram_arbiter
//   Self-checking bench for sdram_arbiter (NUM_PORTS=4, DATA_W=16, ADDR_W=24).
//
//   Inputs are driven 1 ns after the rising edge. Outputs are sampled on the
//   falling edge. Expected completions are pushed to a scoreboard queue when
//   the controller completion is driven. A monitor pops and compares the
//   queue whenever the DUT raises p_rvalid or p_wvalid. A pulse that arrives
//   with an empty queue is an error.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sdram_arbiter;

    localparam int NP = 4;
    localparam int DW = 16;
    localparam int AW = 24;
    localparam int BW = DW / 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP-1:0]    p_rd;
    logic [NP*BW-1:0] p_wr;
    logic [NP*AW-1:0] p_addr;
    logic [NP*DW-1:0] p_wdata;
    logic [NP-1:0]    p_gnt, p_rvalid, p_wvalid;
    logic [DW-1:0]    p_rdata;
    logic             m_rdy, m_rd;
    logic [BW-1:0]    m_wr;
    logic [AW-1:0]    m_addr;
    logic [DW-1:0]    m_wdata;
    logic             m_rvalid, m_wvalid;
    logic [DW-1:0]    m_rdata;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int            port;
        logic          rd;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    typedef struct {
        int            port;
        logic          rd;
        logic [BW-1:0] be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            rdy_delay;
        logic          stray;      // stray completions while IDLE/ISSUE
        logic          both;       // raise m_rvalid and m_wvalid together
        logic          exp_rd;
        logic [BW-1:0] exp_wr;
    } vec_t;

`ifdef SDRAM_ARB_PRIORITY_EN
    int ord34 [5] = '{0, 0, 0, 0, 0};
    int ord38 [4] = '{0, 0, 0, 0};
`else
    int ord34 [5] = '{0, 1, 2, 3, 0};
    int ord38 [4] = '{0, 2, 0, 2};
`endif

    sdram_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .p_rd     (p_rd),
        .p_wr     (p_wr),
        .p_addr   (p_addr),
        .p_wdata  (p_wdata),
        .p_gnt    (p_gnt),
        .p_rvalid (p_rvalid),
        .p_wvalid (p_wvalid),
        .p_rdata  (p_rdata),
        .m_rdy    (m_rdy),
        .m_rd     (m_rd),
        .m_wr     (m_wr),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rvalid (m_rvalid),
        .m_wvalid (m_wvalid),
        .m_rdata  (m_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NP-1:0] onehot(input int p);
        return NP'(1) << p;
    endfunction

    task automatic set_req(input int port, input logic rd, input logic [BW-1:0] be,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        p_rd[port]             = rd;
        p_wr[port*BW +: BW]    = be;
        p_addr[port*AW +: AW]  = addr;
        p_wdata[port*DW +: DW] = wdata;
    endtask

    // Completion monitor / scoreboard
    always @(negedge clk) begin
        if (p_rvalid != '0 || p_wvalid != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 64'({p_rvalid, p_wvalid}), 64'(0));
            end else begin
                mon_e = sb.pop_front();
                chk("p_rvalid", 64'(p_rvalid), 64'(mon_e.rd ? onehot(mon_e.port) : '0));
                chk("p_wvalid", 64'(p_wvalid), 64'(mon_e.rd ? '0 : onehot(mon_e.port)));
                chk("p_rdata",  64'(p_rdata),  64'(mon_e.rd ? mon_e.data : '0));
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drop_all();
        @(posedge clk); #1;
        p_rd = '0; p_wr = '0; p_addr = '0; p_wdata = '0;
        m_rvalid = 1'b0; m_wvalid = 1'b0; m_rdata = '0;
        @(negedge clk);
        chk("sb_drain", 64'(sb.size()), 64'(0));
    endtask

    // Requests are already held by the caller and m_rdy is 1. Wait for the
    // grant, check the registered request, then complete it on the very next
    // cycle.
    task automatic serve_one(input int port, input logic rd, input logic [BW-1:0] be,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                             input logic [DW-1:0] rdata, input int exp_wait);
        int waited;
        bit found;
        found  = 1'b0;
        waited = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(posedge clk); #1;
            m_rvalid = 1'b0; m_wvalid = 1'b0;
            @(negedge clk);
            if (p_gnt != '0) begin
                found  = 1'b1;
                waited = i;
            end
        end
        if (!found) begin
            chk("gnt_timeout", 64'(p_gnt), 64'(onehot(port)));
            return;
        end
        if (exp_wait >= 0)
            chk("gnt_wait", 64'(waited), 64'(exp_wait));
        chk("gnt",     64'(p_gnt),   64'(onehot(port)));
        chk("m_rd",    64'(m_rd),    64'(rd));
        chk("m_wr",    64'(m_wr),    64'(rd ? '0 : be));
        chk("m_addr",  64'(m_addr),  64'(addr));
        chk("m_wdata", 64'(m_wdata), 64'(wdata));
        @(posedge clk); #1;
        m_rdata = rdata;
        if (rd) m_rvalid = 1'b1;
        else    m_wvalid = 1'b1;
        sb.push_back('{port: port, rd: rd, data: rdata});
        @(negedge clk);
        chk("wait_m_req", 64'({m_rd, m_wr}), 64'(0));
    endtask

    // Single-requester transaction with an optional m_rdy stall, stray
    // completions and a dual completion pulse.
    task automatic run_txn(input vec_t v);
        logic [63:0] mexp;
        mexp = 64'({v.exp_rd, v.exp_wr, v.addr, v.wdata});
        @(posedge clk); #1;
        set_req(v.port, v.rd, v.be, v.addr, v.wdata);
        m_rdy = 1'b0;
        m_wvalid = v.stray;
        @(negedge clk);
        chk("idle_gnt",   64'(p_gnt), 64'(0));
        chk("idle_m_req", 64'({m_rd, m_wr, m_addr, m_wdata}), 64'(0));
        @(posedge clk); #1;
        m_wvalid = 1'b0;
        m_rdy = (v.rdy_delay == 0);
        @(negedge clk);
        chk("gnt",     64'(p_gnt),   64'(onehot(v.port)));
        chk("m_req",   64'({m_rd, m_wr, m_addr, m_wdata}), mexp);
        for (int c = 1; c <= v.rdy_delay; c++) begin
            @(posedge clk); #1;
            if (c == 1) set_req(v.port, 1'b0, '0, '0, '0);
            m_rdy    = (c == v.rdy_delay);
            m_rvalid = v.stray;
            m_rdata  = 16'hDEAD;
            @(negedge clk);
            chk("issue_hold", 64'({m_rd, m_wr, m_addr, m_wdata}), mexp);
            chk("issue_gnt",  64'(p_gnt), 64'(0));
        end
        @(posedge clk); #1;
        set_req(v.port, 1'b0, '0, '0, '0);
        m_rdy = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        @(negedge clk);
        chk("wait_m_req", 64'({m_rd, m_wr}), 64'(0));
        @(posedge clk); #1;
        m_rdata  = v.rdata;
        m_rvalid = v.rd | v.both;
        m_wvalid = !v.rd | v.both;
        sb.push_back('{port: v.port, rd: v.rd, data: v.rdata});
        @(negedge clk);
        @(posedge clk); #1;
        m_rvalid = 1'b0; m_wvalid = 1'b0; m_rdata = '0;
        @(negedge clk);
        chk("drain",      64'(sb.size()), 64'(0));
        chk("idle_after", 64'({m_rd, m_wr, m_addr, m_wdata}), 64'(0));
    endtask

    vec_t vt [6];
    logic [BW-1:0] be34 [NP] = '{2'b01, 2'b10, 2'b11, 2'b01};

    initial begin
        //          port rd    be     addr         wdata     rdata     dly stray both  exp_rd exp_wr
        vt[0] = '{2, 1'b1, 2'b00, 24'h000100, 16'h0000, 16'hBEEF, 0,  1'b0, 1'b0, 1'b1, 2'b00};
        vt[1] = '{0, 1'b0, 2'b11, 24'h00ABCD, 16'h1234, 16'h7777, 2,  1'b0, 1'b1, 1'b0, 2'b11};
        vt[2] = '{1, 1'b1, 2'b11, 24'h123456, 16'h0000, 16'h5A5A, 1,  1'b0, 1'b1, 1'b1, 2'b00};
        vt[3] = '{3, 1'b0, 2'b10, 24'hFFFFFE, 16'hFFFF, 16'h0000, 10, 1'b1, 1'b0, 1'b0, 2'b10};
        vt[4] = '{3, 1'b1, 2'b00, 24'hFFFFFF, 16'h0000, 16'h0001, 0,  1'b1, 1'b0, 1'b1, 2'b00};
        vt[5] = '{1, 1'b0, 2'b01, 24'h000000, 16'h00A5, 16'h0000, 3,  1'b0, 1'b0, 1'b0, 2'b01};

        rst = 1'b1;
        p_rd = '0; p_wr = '0; p_addr = '0; p_wdata = '0;
        m_rdy = 1'b1; m_rvalid = 1'b0; m_wvalid = 1'b0; m_rdata = '0;

        // All ports request writes continuously from reset
        for (int k = 0; k < NP; k++)
            set_req(k, 1'b0, be34[k], 24'h000100 * (k + 1), 16'h1000 + 16'(k));
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("rst_p_gnt",    64'(p_gnt),    64'(0));
        chk("rst_p_rvalid", 64'(p_rvalid), 64'(0));
        chk("rst_p_wvalid", 64'(p_wvalid), 64'(0));
        chk("rst_p_rdata",  64'(p_rdata),  64'(0));
        chk("rst_m_req",    64'({m_rd, m_wr, m_addr, m_wdata}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n < 5; n++)
            serve_one(ord34[n], 1'b0, be34[ord34[n]], 24'h000100 * (ord34[n] + 1),
                      16'h1000 + 16'(ord34[n]), 16'h0000, (n == 0) ? 0 : 1);
        drop_all();

        // Ports 0 and 2 read continuously after a fresh reset
        do_reset();
        set_req(0, 1'b1, '0, 24'h0A0000, '0);
        set_req(2, 1'b1, '0, 24'h0C0000, '0);
        for (int n = 0; n < 4; n++)
            serve_one(ord38[n], 1'b1, '0, (ord38[n] == 0) ? 24'h0A0000 : 24'h0C0000,
                      '0, 16'hC000 + 16'(n), (n == 0) ? 0 : 1);
        drop_all();

        // Table of single-port transactions
        for (int i = 0; i < 6; i++)
            run_txn(vt[i]);

        // Reset in WAIT, then a stray completion
        @(posedge clk); #1;
        m_rdy = 1'b1;
        set_req(1, 1'b1, '0, 24'h000222, '0);
        @(negedge clk);
        @(posedge clk); #1;
        set_req(1, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("rw_gnt", 64'(p_gnt), 64'(onehot(1)));
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rw_wait", 64'({m_rd, m_addr}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        m_rvalid = 1'b1; m_rdata = 16'hDEAD;
        @(negedge clk);
        chk("rw_p_rvalid", 64'(p_rvalid), 64'(0));
        chk("rw_p_rdata",  64'(p_rdata),  64'(0));
        chk("rw_p_gnt",    64'({p_gnt, p_wvalid}), 64'(0));
        chk("rw_m_req",    64'({m_rd, m_wr, m_addr, m_wdata}), 64'(0));
        @(posedge clk); #1;
        m_rvalid = 1'b0; m_rdata = '0;
        // The pointer restarts at 0, so port 1 wins over port 3 before port 3 is served
        set_req(1, 1'b1, '0, 24'h000111, '0);
        set_req(3, 1'b1, '0, 24'h000333, '0);
        serve_one(1, 1'b1, '0, 24'h000111, '0, 16'h1111, 0);
        serve_one(3, 1'b1, '0, 24'h000333, '0, 16'h3333, 1);
        drop_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
